// File: rtl/score_pkg.sv
// Shared types, constants and small helpers for the two-digit score readout.
package score_pkg;

    localparam int SCORE_W     = 7;
    localparam int MAX_DISPLAY = 99;
    localparam int CONV_STEPS  = 7;
    localparam int STEP_W      = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_t;

    // Scores above two decimal digits saturate at the largest displayable value.
    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        if (s > SCORE_W'(MAX_DISPLAY)) begin
            r = SCORE_W'(MAX_DISPLAY);
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after the shift.
    function automatic logic [3:0] add3_nibble(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD converter.
// One step per cycle; the result is stable in the accumulator while done=1.
module bin2bcd_seq
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [3:0]         tens,
    output logic [3:0]         ones
);

    conv_state_t        state_q, state_d;
    logic [SCORE_W-1:0] shift_q, shift_d;
    logic [7:0]         acc_q, acc_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [7:0]         adj_s;

    // Next-state logic: load on start, run CONV_STEPS shift-add-3 steps, hold for one commit cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        step_d  = step_q;
        adj_s   = 8'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    acc_d   = 8'd0;
                    step_d  = STEP_W'(0);
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                adj_s   = {add3_nibble(acc_q[7:4]), add3_nibble(acc_q[3:0])};
                acc_d   = {adj_s[6:0], shift_q[SCORE_W-1]};
                shift_d = {shift_q[SCORE_W-2:0], 1'b0};
                if (step_q == STEP_W'(CONV_STEPS - 1)) begin
                    step_d  = STEP_W'(0);
                    state_d = COMMIT;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Converter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= SCORE_W'(0);
            acc_q   <= 8'd0;
            step_q  <= STEP_W'(0);
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == COMMIT);
    assign tens = acc_q[7:4];
    assign ones = acc_q[3:0];

endmodule

// File: rtl/score_scan_ctrl.sv
// Two-digit score display controller: captures score updates, converts them to BCD,
// and time-multiplexes tens/ones onto a shared decoder with zero blanking and blinking.
module score_scan_ctrl
    import score_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    input  logic               game_over,
    output logic [3:0]         digit,
    output logic               en_ones,
    output logic               en_tens,
    output logic               busy
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

    logic               conv_busy_s, conv_done_s;
    logic [3:0]         conv_tens_s, conv_ones_s;
    logic               start_s;
    logic [SCORE_W-1:0] clamped_s, start_val_s;
    logic               scan_tc_s, frame_tick_s;

    logic               pend_valid_q, pend_valid_d;
    logic [SCORE_W-1:0] pend_val_q, pend_val_d;
    logic [3:0]         tens_q, tens_d, ones_q, ones_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    slot_t              slot_q, slot_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [3:0]         digit_q, digit_d;
    logic               en_ones_q, en_ones_d, en_tens_q, en_tens_d;

    assign clamped_s = clamp_score(score);

    // A new strobe takes priority over an older pending value, which it supersedes.
    assign start_s     = ~conv_busy_s & (score_valid | pend_valid_q);
    assign start_val_s = score_valid ? clamped_s : pend_val_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .bin   (start_val_s),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .tens  (conv_tens_s),
        .ones  (conv_ones_s)
    );

    // Pending slot and displayed pair: updates during a conversion queue one deep, result lands on commit.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_val_d   = pend_val_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        if (conv_busy_s && score_valid) begin
            pend_valid_d = 1'b1;
            pend_val_d   = clamped_s;
        end else if (start_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        if (conv_done_s) begin
            tens_d = conv_tens_s;
            ones_d = conv_ones_s;
        end else begin
            tens_d = tens_q;
            ones_d = ones_q;
        end
    end

    assign scan_tc_s    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign frame_tick_s = scan_tc_s & (slot_q == SLOT_TENS);

    // Scan slot timing and game-over blink phase.
    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        slot_d      = slot_q;
        frame_cnt_d = frame_cnt_q;
        blink_off_d = blink_off_q;
        if (scan_tc_s) begin
            scan_cnt_d = SCAN_W'(0);
            slot_d     = (slot_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
        if (!game_over) begin
            frame_cnt_d = FRAME_W'(0);
            blink_off_d = 1'b0;
        end else if (frame_tick_s) begin
            if (frame_cnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = FRAME_W'(0);
                blink_off_d = ~blink_off_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Output stage: digit select, ones enable, and tens enable with leading-zero blanking.
    always_comb begin
        digit_d   = (slot_q == SLOT_TENS) ? tens_q : ones_q;
        en_ones_d = (slot_q == SLOT_ONES) & ~blink_off_q;
        en_tens_d = (slot_q == SLOT_TENS) & ~blink_off_q & (tens_q != 4'd0);
    end

    // All top-level state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_val_q   <= SCORE_W'(0);
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            scan_cnt_q   <= SCAN_W'(0);
            slot_q       <= SLOT_ONES;
            frame_cnt_q  <= FRAME_W'(0);
            blink_off_q  <= 1'b0;
            digit_q      <= 4'd0;
            en_ones_q    <= 1'b0;
            en_tens_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_val_q   <= pend_val_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            scan_cnt_q   <= scan_cnt_d;
            slot_q       <= slot_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_off_q  <= blink_off_d;
            digit_q      <= digit_d;
            en_ones_q    <= en_ones_d;
            en_tens_q    <= en_tens_d;
        end
    end

    assign digit   = digit_q;
    assign en_ones = en_ones_q;
    assign en_tens = en_tens_q;
    assign busy    = conv_busy_s;

endmodule
